regfile_sb: RTL and testbench

Parametrised two-write, two-read general-purpose register file with a per-register outstanding-write scoreboard and a debug read port. It serves the decode stage of the 5-stage pipeline. Operand reads are combinational. Register and scoreboard updates occur on the rising edge of `clk`. Decode uses the busy outputs to generate RAW stalls instead of relying on forwarding alone.

---
 rtl/regfile_sb.sv | 129 ++++++++++++
 tb/tb_regfile_sb.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// Two-write/two-read register file with per-register outstanding-producer scoreboard and debug readout.
// Optional same-cycle write bypass and busy suppression: define REGFILE_BYPASS_EN.
module regfile_sb #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned CNT_W    = 2,
    parameter int unsigned DBG_ADDR = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_a,
    input  logic [ADDR_W-1:0] wa_a,
    input  logic [DATA_W-1:0] wd_a,
    input  logic              we_b,
    input  logic [ADDR_W-1:0] wa_b,
    input  logic [DATA_W-1:0] wd_b,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    output logic              rd1_busy,
    output logic              rd2_busy,
    input  logic              iss_valid,
    input  logic [ADDR_W-1:0] iss_addr,
    output logic              iss_stall,
    input  logic              dbg_sel,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    localparam int unsigned       DEPTH        = 1 << ADDR_W;
    localparam logic [CNT_W-1:0]  CNT_MAX      = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  CNT_ONE      = CNT_W'(1);
    localparam logic [ADDR_W-1:0] DBG_DEF_ADDR = ADDR_W'(DBG_ADDR);

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];
    logic [CNT_W-1:0]  cnt_q  [DEPTH];
    logic [CNT_W-1:0]  cnt_d  [DEPTH];
    logic [DATA_W-1:0] dbg_q;
    logic [DATA_W-1:0] dbg_d;

    logic [DEPTH-1:0]  hit_vec;
    logic [DEPTH-1:0]  inc_vec;

    // Registers hit by either write port this cycle (r0 excluded: never tracked)
    always_comb begin
        hit_vec = '0;
        if (we_a) hit_vec[wa_a] = 1'b1;
        if (we_b) hit_vec[wa_b] = 1'b1;
        hit_vec[0] = 1'b0;
    end

    assign iss_stall = iss_valid && (iss_addr != '0) && (cnt_q[iss_addr] == CNT_MAX)
                       && !hit_vec[iss_addr];

    always_comb begin
        inc_vec = '0;
        if (iss_valid && !iss_stall) inc_vec[iss_addr] = 1'b1;
        inc_vec[0] = 1'b0;
    end

    // Counter update: issue and write on the same edge cancel; decrement saturates at 0
    always_comb begin
        for (int r = 0; r < int'(DEPTH); r++) begin
            cnt_d[r] = cnt_q[r];
            if (inc_vec[r] && !hit_vec[r]) begin
                cnt_d[r] = cnt_q[r] + CNT_ONE;
            end else if (hit_vec[r] && !inc_vec[r] && (cnt_q[r] != '0)) begin
                cnt_d[r] = cnt_q[r] - CNT_ONE;
            end
        end
        cnt_d[0] = '0;
    end

    // Array update; port B applied last so it wins on an address conflict
    always_comb begin
        regs_d = regs_q;
        if (we_a) regs_d[wa_a] = wd_a;
        if (we_b) regs_d[wa_b] = wd_b;
        regs_d[0] = '0;
    end

    assign dbg_d = regs_q[dbg_sel ? dbg_addr : DBG_DEF_ADDR];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < int'(DEPTH); r++) begin
                regs_q[r] <= '0;
                cnt_q[r]  <= '0;
            end
            dbg_q <= '0;
        end else begin
            for (int r = 0; r < int'(DEPTH); r++) begin
                regs_q[r] <= regs_d[r];
                cnt_q[r]  <= cnt_d[r];
            end
            dbg_q <= dbg_d;
        end
    end

    assign dbg_data = dbg_q;

`ifdef REGFILE_BYPASS_EN
    // Forward same-cycle write data and release busy on the final outstanding writeback
    always_comb begin
        rd1 = regs_q[ra1];
        rd2 = regs_q[ra2];
        if (ra1 != '0) begin
            if (we_b && (wa_b == ra1))      rd1 = wd_b;
            else if (we_a && (wa_a == ra1)) rd1 = wd_a;
        end
        if (ra2 != '0) begin
            if (we_b && (wa_b == ra2))      rd2 = wd_b;
            else if (we_a && (wa_a == ra2)) rd2 = wd_a;
        end
        rd1_busy = (cnt_q[ra1] != '0) && !((cnt_q[ra1] == CNT_ONE) && hit_vec[ra1]);
        rd2_busy = (cnt_q[ra2] != '0) && !((cnt_q[ra2] == CNT_ONE) && hit_vec[ra2]);
    end
`else
    always_comb begin
        rd1      = regs_q[ra1];
        rd2      = regs_q[ra2];
        rd1_busy = (cnt_q[ra1] != '0);
        rd2_busy = (cnt_q[ra2] != '0);
    end
`endif

endmodule

// File: tb/tb_regfile_sb.sv
// Directed table-driven bench for regfile_sb; expectations follow REGFILE_BYPASS_EN when defined.
module tb_regfile_sb;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        we_a, we_b, iss_valid, dbg_sel;
    logic [4:0]  wa_a, wa_b, ra1, ra2, iss_addr, dbg_addr;
    logic [31:0] wd_a, wd_b, rd1, rd2, dbg_data;
    logic        rd1_busy, rd2_busy, iss_stall;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    regfile_sb #(.DATA_W(32), .ADDR_W(5), .CNT_W(2), .DBG_ADDR(9)) dut (
        .clk(clk), .rst(rst),
        .we_a(we_a), .wa_a(wa_a), .wd_a(wd_a),
        .we_b(we_b), .wa_b(wa_b), .wd_b(wd_b),
        .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
        .rd1_busy(rd1_busy), .rd2_busy(rd2_busy),
        .iss_valid(iss_valid), .iss_addr(iss_addr), .iss_stall(iss_stall),
        .dbg_sel(dbg_sel), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    typedef struct packed {
        logic        rst;
        logic        we_a;
        logic [4:0]  wa_a;
        logic [31:0] wd_a;
        logic        we_b;
        logic [4:0]  wa_b;
        logic [31:0] wd_b;
        logic [4:0]  ra1;
        logic [4:0]  ra2;
        logic        iv;
        logic [4:0]  ia;
        logic        ds;
        logic [4:0]  da;
        logic [31:0] e_rd1;
        logic [31:0] e_rd2;
        logic        e_b1;
        logic        e_b2;
        logic        e_st;
        logic [31:0] e_dbg;
    } vec_t;

    localparam int NV = 36;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic r, input logic wea, input int waa, input logic [31:0] wda,
                                input logic web, input int wab, input logic [31:0] wdb,
                                input int a1, input int a2, input logic iv, input int ia,
                                input logic ds, input int da,
                                input logic [31:0] e1, input logic [31:0] e2,
                                input logic b1, input logic b2, input logic st, input logic [31:0] ed);
        vec_t v;
        v.rst = r; v.we_a = wea; v.wa_a = 5'(waa); v.wd_a = wda;
        v.we_b = web; v.wa_b = 5'(wab); v.wd_b = wdb;
        v.ra1 = 5'(a1); v.ra2 = 5'(a2); v.iv = iv; v.ia = 5'(ia);
        v.ds = ds; v.da = 5'(da);
        v.e_rd1 = e1; v.e_rd2 = e2; v.e_b1 = b1; v.e_b2 = b2; v.e_st = st; v.e_dbg = ed;
        return v;
    endfunction

    function automatic logic [31:0] bp(input logic [31:0] with_byp, input logic [31:0] without);
        return BYP ? with_byp : without;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s step %0d: got 0x%0h, expected 0x%0h", name, idx, act, exp);
    endtask

    task automatic idle_inputs();
        rst = 1'b0; we_a = 1'b0; wa_a = '0; wd_a = '0;
        we_b = 1'b0; wa_b = '0; wd_b = '0;
        ra1 = '0; ra2 = '0; iss_valid = 1'b0; iss_addr = '0;
        dbg_sel = 1'b0; dbg_addr = '0;
    endtask

    logic [31:0] model [32];

    initial begin
        //            rst wea waa wda        web wab wdb        ra1 ra2 iv ia ds da | rd1 rd2 b1 b2 st dbg
        vecs[0]  = mk(0, 1, 5, 32'h1234, 0, 0, 32'h0,    5, 0, 0, 0, 0, 0, bp(32'h1234, 0), 0, 0, 0, 0, 0);
        vecs[1]  = mk(1, 1, 5, 32'hFFFF, 0, 0, 32'h0,    5, 0, 0, 0, 0, 0, bp(32'hFFFF, 32'h1234), 0, 0, 0, 0, 0);
        vecs[2]  = mk(0, 0, 0, 32'h0,    0, 0, 32'h0,    5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[3]  = mk(0, 1, 7, 32'hAAAA, 1, 7, 32'hBBBB, 7, 0, 0, 0, 0, 0, bp(32'hBBBB, 0), 0, 0, 0, 0, 0);
        vecs[4]  = mk(0, 1, 0, 32'h55,   0, 0, 32'h0,    7, 0, 0, 0, 0, 0, 32'hBBBB, 0, 0, 0, 0, 0);
        vecs[5]  = mk(0, 0, 0, 32'h0,    1, 9, 32'h42,   0, 9, 0, 0, 0, 0, 0, bp(32'h42, 0), 0, 0, 0, 0);
        vecs[6]  = mk(0, 1, 3, 32'hCAFE, 0, 0, 32'h0,    3, 9, 0, 0, 0, 0, bp(32'hCAFE, 0), 32'h42, 0, 0, 0, 0);
        vecs[7]  = mk(0, 0, 0, 32'h0,    1, 5, 32'h77,   3, 5, 0, 0, 1, 5, 32'hCAFE, bp(32'h77, 0), 0, 0, 0, 32'h42);
        vecs[8]  = mk(0, 0, 0, 32'h0,    0, 0, 32'h0,    3, 5, 0, 0, 1, 5, 32'hCAFE, 32'h77, 0, 0, 0, 0);
        vecs[9]  = mk(0, 0, 0, 32'h0,    0, 0, 32'h0,    3, 5, 0, 0, 0, 0, 32'hCAFE, 32'h77, 0, 0, 0, 32'h77);
        vecs[10] = mk(0, 0, 0, 32'h0,    0, 0, 32'h0,    4, 0, 1, 4, 0, 0, 0, 0, 0, 0, 0, 32'h42);
        vecs[11] = mk(0, 0, 0, 32'h0,    0, 0, 32'h0,    4, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 32'h42);
        vecs[12] = mk(0, 0, 0, 32'h0,    0, 0, 32'h0,    4, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 32'h42);
        vecs[13] = mk(0, 1, 4, 32'h44,   0, 0, 32'h0,    4, 0, 0, 0, 0, 0, bp(32'h44, 0), 0, !BYP, 0, 0, 32'h42);
        vecs[14] = mk(0, 0, 0, 32'h0,    0, 0, 32'h0,    4, 0, 0, 0, 0, 0, 32'h44, 0, 0, 0, 0, 32'h42);
        vecs[15] = mk(0, 0, 0, 32'h0,    0, 0, 32'h0,    8, 8, 1, 8, 0, 0, 0, 0, 0, 0, 0, 32'h42);
        vecs[16] = mk(0, 0, 0, 32'h0,    0, 0, 32'h0,    8, 8, 1, 8, 0, 0, 0, 0, 1, 1, 0, 32'h42);
        vecs[17] = mk(0, 0, 0, 32'h0,    0, 0, 32'h0,    8, 8, 1, 8, 0, 0, 0, 0, 1, 1, 0, 32'h42);
        vecs[18] = mk(0, 0, 0, 32'h0,    0, 0, 32'h0,    8, 8, 1, 8, 0, 0, 0, 0, 1, 1, 1, 32'h42);
        vecs[19] = mk(0, 0, 0, 32'h0,    1, 8, 32'h88,   8, 8, 1, 8, 0, 0, bp(32'h88, 0), bp(32'h88, 0), 1, 1, 0, 32'h42);
        vecs[20] = mk(0, 0, 0, 32'h0,    0, 0, 32'h0,    8, 8, 1, 8, 0, 0, 32'h88, 32'h88, 1, 1, 1, 32'h42);
        vecs[21] = mk(0, 1, 8, 32'h91,   1, 8, 32'h92,   8, 8, 0, 0, 0, 0, bp(32'h92, 32'h88), bp(32'h92, 32'h88), 1, 1, 0, 32'h42);
        vecs[22] = mk(0, 0, 0, 32'h0,    0, 0, 32'h0,    8, 8, 1, 8, 0, 0, 32'h92, 32'h92, 1, 1, 0, 32'h42);
        vecs[23] = mk(0, 0, 0, 32'h0,    0, 0, 32'h0,    8, 8, 1, 8, 0, 0, 32'h92, 32'h92, 1, 1, 1, 32'h42);
        vecs[24] = mk(0, 1, 8, 32'hA1,   0, 0, 32'h0,    8, 8, 0, 0, 0, 0, bp(32'hA1, 32'h92), bp(32'hA1, 32'h92), 1, 1, 0, 32'h42);
        vecs[25] = mk(0, 1, 8, 32'hA2,   0, 0, 32'h0,    8, 8, 0, 0, 0, 0, bp(32'hA2, 32'hA1), bp(32'hA2, 32'hA1), 1, 1, 0, 32'h42);
        vecs[26] = mk(0, 1, 8, 32'hA3,   0, 0, 32'h0,    8, 8, 0, 0, 0, 0, bp(32'hA3, 32'hA2), bp(32'hA3, 32'hA2), !BYP, !BYP, 0, 32'h42);
        vecs[27] = mk(0, 0, 0, 32'h0,    1, 8, 32'hA4,   8, 8, 0, 0, 0, 0, bp(32'hA4, 32'hA3), bp(32'hA4, 32'hA3), 0, 0, 0, 32'h42);
        vecs[28] = mk(0, 0, 0, 32'h0,    0, 0, 32'h0,    8, 8, 1, 8, 0, 0, 32'hA4, 32'hA4, 0, 0, 0, 32'h42);
        vecs[29] = mk(0, 0, 0, 32'h0,    0, 0, 32'h0,    8, 8, 0, 0, 0, 0, 32'hA4, 32'hA4, 1, 1, 0, 32'h42);
        vecs[30] = mk(1, 0, 0, 32'h0,    0, 0, 32'h0,    8, 8, 0, 0, 0, 0, 32'hA4, 32'hA4, 1, 1, 0, 32'h42);
        vecs[31] = mk(0, 1, 8, 32'hB1,   0, 0, 32'h0,    8, 8, 0, 0, 0, 0, bp(32'hB1, 0), bp(32'hB1, 0), 0, 0, 0, 0);
        vecs[32] = mk(0, 0, 0, 32'h0,    0, 0, 32'h0,    8, 0, 1, 8, 0, 0, 32'hB1, 0, 0, 0, 0, 0);
        vecs[33] = mk(0, 0, 0, 32'h0,    0, 0, 32'h0,    8, 0, 0, 0, 0, 0, 32'hB1, 0, 1, 0, 0, 0);
        vecs[34] = mk(0, 0, 0, 32'h0,    0, 0, 32'h0,    0, 8, 1, 0, 0, 0, 0, 32'hB1, 0, 1, 0, 0);
        vecs[35] = mk(0, 0, 0, 32'h0,    0, 0, 32'h0,    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        idle_inputs();
        rst = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < NV; i++) begin
            rst = vecs[i].rst;
            we_a = vecs[i].we_a; wa_a = vecs[i].wa_a; wd_a = vecs[i].wd_a;
            we_b = vecs[i].we_b; wa_b = vecs[i].wa_b; wd_b = vecs[i].wd_b;
            ra1 = vecs[i].ra1; ra2 = vecs[i].ra2;
            iss_valid = vecs[i].iv; iss_addr = vecs[i].ia;
            dbg_sel = vecs[i].ds; dbg_addr = vecs[i].da;
            @(negedge clk);
            chk("rd1", i, rd1, vecs[i].e_rd1);
            chk("rd2", i, rd2, vecs[i].e_rd2);
            chk("rd1_busy", i, 32'(rd1_busy), 32'(vecs[i].e_b1));
            chk("rd2_busy", i, 32'(rd2_busy), 32'(vecs[i].e_b2));
            chk("iss_stall", i, 32'(iss_stall), 32'(vecs[i].e_st));
            chk("dbg_data", i, dbg_data, vecs[i].e_dbg);
            @(posedge clk); #1;
        end

        // Fill r10..r20 through port B, then read back on both ports in crossed order
        idle_inputs();
        for (int r = 10; r <= 20; r++) begin
            we_b = 1'b1; wa_b = 5'(r); wd_b = 32'h1000 + 32'(r * 3);
            model[r] = wd_b;
            @(posedge clk); #1;
        end
        idle_inputs();
        for (int r = 10; r <= 20; r++) begin
            ra1 = 5'(r); ra2 = 5'(30 - r);
            @(negedge clk);
            chk("fill_rd1", r, rd1, model[r]);
            chk("fill_rd2", r, rd2, model[30 - r]);
            chk("fill_busy", r, 32'(rd1_busy | rd2_busy), 32'h0);
            @(posedge clk); #1;
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
